// File: rtl/fir_pkg.sv
// Shared definitions for the FIR configuration sequencer: register map, ap_ctrl bits,
// error codes and sequencer states.
package fir_pkg;

   localparam logic [11:0] ADDR_AP_CTRL  = 12'h00;
   localparam logic [11:0] ADDR_LEN      = 12'h10;
   localparam logic [11:0] ADDR_TAP_BASE = 12'h20;

   localparam int unsigned AP_START_BIT = 0;
   localparam int unsigned AP_DONE_BIT  = 1;
   localparam int unsigned AP_IDLE_BIT  = 2;

   typedef enum logic [1:0] {
      ErrNone        = 2'd0,
      ErrTapMismatch = 2'd1,
      ErrPollTimeout = 2'd2
   } err_code_e;

   typedef enum logic [2:0] {
      StIdle,
      StWrLen,
      StWrTap,
      StRdTap,
      StWrStart,
      StWaitGap,
      StPoll,
      StDone
   } seq_state_e;

   function automatic logic [11:0] tap_addr(input logic [3:0] idx);
      return ADDR_TAP_BASE + {6'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/axil_master_port.sv
// Single-transaction AXI-Lite master: one write (AW+W) or one read (AR+R) per req,
// ack pulses for one cycle once every handshake of that transaction has completed.
module axil_master_port #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic          ack_o,
   output logic [DW-1:0] rdata_o,
   output logic          awvalid_o,
   output logic [AW-1:0] awaddr_o,
   input  logic          awready_i,
   output logic          wvalid_o,
   output logic [DW-1:0] wdata_o,
   input  logic          wready_i,
   output logic          arvalid_o,
   output logic [AW-1:0] araddr_o,
   input  logic          arready_i,
   output logic          rready_o,
   input  logic          rvalid_i,
   input  logic [DW-1:0] rdata_i
);

   logic          active_q, we_q, ack_q;
   logic          aw_done_q, w_done_q, ar_done_q;
   logic          awvalid_q, wvalid_q, arvalid_q, rready_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata_q;
   logic          aw_hs, w_hs, ar_hs, r_hs;

   assign aw_hs = awvalid_q & awready_i;
   assign w_hs  = wvalid_q & wready_i;
   assign ar_hs = arvalid_q & arready_i;
   // Read data is only accepted once its address has been taken.
   assign r_hs  = rready_q & rvalid_i & (ar_done_q | ar_hs);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q  <= 1'b0;
         we_q      <= 1'b0;
         ack_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ar_done_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         ack_q <= 1'b0;
         if (!active_q) begin
            if (req_i) begin
               active_q  <= 1'b1;
               we_q      <= we_i;
               addr_q    <= addr_i;
               wdata_q   <= wdata_i;
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
               ar_done_q <= 1'b0;
               awvalid_q <= we_i;
               wvalid_q  <= we_i;
               arvalid_q <= ~we_i;
               rready_q  <= ~we_i;
            end
         end else if (we_q) begin
            if (aw_hs) begin
               awvalid_q <= 1'b0;
               aw_done_q <= 1'b1;
            end
            if (w_hs) begin
               wvalid_q <= 1'b0;
               w_done_q <= 1'b1;
            end
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               active_q <= 1'b0;
               ack_q    <= 1'b1;
            end
         end else begin
            if (ar_hs) begin
               arvalid_q <= 1'b0;
               ar_done_q <= 1'b1;
            end
            if (r_hs) begin
               rready_q <= 1'b0;
               rdata_q  <= rdata_i;
               active_q <= 1'b0;
               ack_q    <= 1'b1;
            end
         end
      end
   end

   assign ack_o     = ack_q;
   assign rdata_o   = rdata_q;
   assign awvalid_o = awvalid_q;
   assign awaddr_o  = addr_q;
   assign wvalid_o  = wvalid_q;
   assign wdata_o   = wdata_q;
   assign arvalid_o = arvalid_q;
   assign araddr_o  = addr_q;
   assign rready_o  = rready_q;

endmodule

// File: rtl/fir_cfg_sequencer.sv
// Autonomous AXI-Lite configurator for the FIR engine: writes length and taps, optionally
// verifies the taps, starts the engine and polls ap_ctrl until ap_done or timeout.
module fir_cfg_sequencer
   import fir_pkg::*;
#(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned Tape_Num    = 11,
   parameter int unsigned VERIFY      = 1,
   parameter int unsigned POLL_GAP    = 4,
   parameter int unsigned TIMEOUT     = 100000
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   go,
   input  logic [pDATA_WIDTH-1:0] cfg_len,
   output logic [3:0]             coef_idx,
   input  logic [pDATA_WIDTH-1:0] coef_data,
   output logic                   awvalid,
   output logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   awready,
   output logic                   wvalid,
   output logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   wready,
   output logic                   arvalid,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   arready,
   output logic                   rready,
   input  logic                   rvalid,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [3:0]             err_idx
);

   seq_state_e             state_q;
   logic                   busy_q, done_q, err_q;
   err_code_e              err_code_q;
   logic [3:0]             err_idx_q, tap_q;
   logic [pDATA_WIDTH-1:0] len_q, req_wdata_q;
   logic [pADDR_WIDTH-1:0] req_addr_q;
   logic                   req_q, req_we_q, issued_q;
   logic [31:0]            gap_cnt_q, poll_cnt_q;

   logic                   port_ack;
   logic [pDATA_WIDTH-1:0] port_rdata;
   logic                   bus_state, last_tap, timed_out, abort;
   logic                   issue_we;
   logic [pADDR_WIDTH-1:0] issue_addr;
   logic [pDATA_WIDTH-1:0] issue_wdata;

   always_comb begin
      issue_we    = 1'b1;
      issue_addr  = pADDR_WIDTH'(ADDR_AP_CTRL);
      issue_wdata = '0;
      case (state_q)
         StWrLen: begin
            issue_addr  = pADDR_WIDTH'(ADDR_LEN);
            issue_wdata = len_q;
         end
         StWrTap: begin
            issue_addr  = pADDR_WIDTH'(tap_addr(tap_q));
            issue_wdata = coef_data;
         end
         StRdTap: begin
            issue_we   = 1'b0;
            issue_addr = pADDR_WIDTH'(tap_addr(tap_q));
         end
         StWrStart: issue_wdata = pDATA_WIDTH'(1) << AP_START_BIT;
         StPoll:    issue_we = 1'b0;
         default:   ;
      endcase
   end

   assign bus_state = state_q inside {StWrLen, StWrTap, StRdTap, StWrStart, StPoll};
   assign last_tap  = tap_q == 4'(Tape_Num - 1);
   assign timed_out = poll_cnt_q >= 32'(TIMEOUT - 1);
   // A poll read already in flight is allowed to finish before giving up.
   assign abort     = timed_out &&
                      ((state_q == StWaitGap) ||
                       (state_q == StPoll && (!issued_q || (port_ack && !port_rdata[AP_DONE_BIT]))));

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ErrNone;
         err_idx_q   <= '0;
         tap_q       <= '0;
         len_q       <= '0;
         req_q       <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         issued_q    <= 1'b0;
         gap_cnt_q   <= '0;
         poll_cnt_q  <= '0;
      end else begin
         req_q  <= 1'b0;
         done_q <= 1'b0;
         if ((state_q == StWaitGap || state_q == StPoll) && poll_cnt_q < 32'(TIMEOUT)) begin
            poll_cnt_q <= poll_cnt_q + 32'd1;
         end
         if (abort) begin
            err_q      <= 1'b1;
            err_code_q <= ErrPollTimeout;
            busy_q     <= 1'b0;
            issued_q   <= 1'b0;
            state_q    <= StIdle;
         end else begin
            if (bus_state && !issued_q) begin
               req_q       <= 1'b1;
               issued_q    <= 1'b1;
               req_we_q    <= issue_we;
               req_addr_q  <= issue_addr;
               req_wdata_q <= issue_wdata;
            end
            case (state_q)
               StIdle: begin
                  if (go) begin
                     len_q      <= cfg_len;
                     err_q      <= 1'b0;
                     err_code_q <= ErrNone;
                     err_idx_q  <= '0;
                     tap_q      <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= StWrLen;
                  end
               end
               StWrLen: begin
                  if (port_ack) begin
                     issued_q <= 1'b0;
                     state_q  <= StWrTap;
                  end
               end
               StWrTap: begin
                  if (port_ack) begin
                     issued_q <= 1'b0;
                     if (VERIFY != 0) begin
                        state_q <= StRdTap;
                     end else if (last_tap) begin
                        state_q <= StWrStart;
                     end else begin
                        tap_q <= tap_q + 4'd1;
                     end
                  end
               end
               StRdTap: begin
                  if (port_ack) begin
                     issued_q <= 1'b0;
                     if (port_rdata != coef_data && !err_q) begin
                        err_q      <= 1'b1;
                        err_code_q <= ErrTapMismatch;
                        err_idx_q  <= tap_q;
                     end
                     if (last_tap) begin
                        state_q <= StWrStart;
                     end else begin
                        tap_q   <= tap_q + 4'd1;
                        state_q <= StWrTap;
                     end
                  end
               end
               StWrStart: begin
                  if (port_ack) begin
                     issued_q   <= 1'b0;
                     poll_cnt_q <= '0;
                     gap_cnt_q  <= '0;
                     state_q    <= StWaitGap;
                  end
               end
               StWaitGap: begin
                  if (gap_cnt_q + 32'd1 >= 32'(POLL_GAP)) begin
                     gap_cnt_q <= '0;
                     state_q   <= StPoll;
                  end else begin
                     gap_cnt_q <= gap_cnt_q + 32'd1;
                  end
               end
               StPoll: begin
                  if (port_ack) begin
                     issued_q <= 1'b0;
                     if (port_rdata[AP_DONE_BIT]) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                     end else begin
                        state_q <= StWaitGap;
                     end
                  end
               end
               StDone:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   axil_master_port #(
      .AW(pADDR_WIDTH),
      .DW(pDATA_WIDTH)
   ) u_port (
      .clk_i    (axis_clk),
      .rst_ni   (axis_rst_n),
      .req_i    (req_q),
      .we_i     (req_we_q),
      .addr_i   (req_addr_q),
      .wdata_i  (req_wdata_q),
      .ack_o    (port_ack),
      .rdata_o  (port_rdata),
      .awvalid_o(awvalid),
      .awaddr_o (awaddr),
      .awready_i(awready),
      .wvalid_o (wvalid),
      .wdata_o  (wdata),
      .wready_i (wready),
      .arvalid_o(arvalid),
      .araddr_o (araddr),
      .arready_i(arready),
      .rready_o (rready),
      .rvalid_i (rvalid),
      .rdata_i  (rdata)
   );

   assign coef_idx = tap_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// Bench for fir_cfg_sequencer: an AXI-Lite slave model standing in for the FIR engine,
// table-driven full sequences plus a hand-written mid-transaction reset.
module tb_fir_cfg_sequencer;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n = 1'b0;
   logic        go = 1'b0;
   logic [31:0] cfg_len = '0;
   logic [3:0]  coef_idx;
   logic [31:0] coef_data;
   logic        awvalid, awready, wvalid, wready, arvalid, arready, rready;
   logic        rvalid = 1'b0;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata;
   logic [31:0] rdata = '0;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [3:0]  err_idx;

   fir_cfg_sequencer #(
      .pADDR_WIDTH(12),
      .pDATA_WIDTH(32),
      .Tape_Num   (11),
      .VERIFY     (1),
      .POLL_GAP   (4),
      .TIMEOUT    (200)
   ) dut (
      .axis_clk  (axis_clk),
      .axis_rst_n(axis_rst_n),
      .go        (go),
      .cfg_len   (cfg_len),
      .coef_idx  (coef_idx),
      .coef_data (coef_data),
      .awvalid   (awvalid),
      .awaddr    (awaddr),
      .awready   (awready),
      .wvalid    (wvalid),
      .wdata     (wdata),
      .wready    (wready),
      .arvalid   (arvalid),
      .araddr    (araddr),
      .arready   (arready),
      .rready    (rready),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .err_idx   (err_idx)
   );

   always #5 axis_clk = ~axis_clk;

   logic [31:0] coef_tab [16];
   assign coef_data = coef_tab[coef_idx];

   // Slave model configuration (written only by the test process)
   int aw_lat = 0, w_lat = 0, corrupt_idx = -1;
   bit never_done = 1'b0;

   // Slave model state (written only by the slave process)
   int          aw_cnt = 0, w_cnt = 0, ctrl_reads = 0, tap_reads = 0, viol = 0;
   int          cyc = 0, start_cyc = 0;
   bit          aw_got = 0, w_got = 0, start_seen = 0, aw_hs_p = 0, w_hs_p = 0;
   logic [11:0] aw_a = '0;
   logic [31:0] w_d = '0;
   logic [31:0] tap_mem [16];
   logic [11:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];

   assign awready = awvalid && (aw_cnt >= aw_lat);
   assign wready  = wvalid && (w_cnt >= w_lat);
   assign arready = arvalid;

   always @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         aw_cnt     <= 0;
         w_cnt      <= 0;
         aw_got     <= 0;
         w_got      <= 0;
         rvalid     <= 1'b0;
         start_seen <= 0;
         ctrl_reads <= 0;
         aw_hs_p    <= 0;
         w_hs_p     <= 0;
      end else begin
         cyc    <= cyc + 1;
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
         if (awvalid && awready) begin
            aw_got <= 1;
            aw_a   <= awaddr;
         end
         if (wvalid && wready) begin
            w_got <= 1;
            w_d   <= wdata;
         end
         if (aw_got && w_got) begin
            aw_got <= 0;
            w_got  <= 0;
            wr_addr_q.push_back(aw_a);
            wr_data_q.push_back(w_d);
            if (aw_a == 12'h000 && w_d[0]) begin
               start_seen <= 1;
               ctrl_reads <= 0;
               start_cyc  <= cyc;
            end else if (aw_a >= 12'h020) begin
               tap_mem[int'(aw_a[7:2]) - 8] <= w_d;
            end
         end
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            if (araddr == 12'h000) begin
               rdata      <= {29'd0, 1'b0, (start_seen && ctrl_reads >= 2 && !never_done), 1'b0};
               ctrl_reads <= ctrl_reads + 1;
            end else begin
               tap_reads <= tap_reads + 1;
               rdata     <= ((int'(araddr[7:2]) - 8) == corrupt_idx) ? 32'd62
                                                                      : tap_mem[int'(araddr[7:2]) - 8];
            end
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
         // Protocol monitor: valid lingering after its handshake, or write and read overlap
         if ((aw_hs_p && awvalid) || (w_hs_p && wvalid) || ((awvalid || wvalid) && arvalid)) begin
            viol <= viol + 1;
         end
         aw_hs_p <= awvalid && awready;
         w_hs_p  <= wvalid && wready;
      end
   end

   int n_chk = 0, n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic logic [43:0] exp_wr(input int k, input logic [31:0] len);
      if (k == 0) return {12'h010, len};
      if (k <= 11) return {12'h020 + 12'(4 * (k - 1)), coef_tab[k-1]};
      return {12'h000, 32'h1};
   endfunction

   typedef struct {
      string       name;
      int          aw_lat;
      int          w_lat;
      int          corrupt_idx;
      bit          never_done;
      int          mid_go;
      logic [31:0] len;
      bit          exp_err;
      logic [1:0]  exp_code;
      logic [3:0]  exp_idx;
      int          exp_done;
   } scen_t;

   task automatic run_scenario(input scen_t s);
      int base_w, base_tr, base_v, dones, lat;
      bit fired;
      logic [43:0] got;
      aw_lat      = s.aw_lat;
      w_lat       = s.w_lat;
      corrupt_idx = s.corrupt_idx;
      never_done  = s.never_done;
      base_w  = wr_addr_q.size();
      base_tr = tap_reads;
      base_v  = viol;
      @(negedge axis_clk);
      go      = 1'b1;
      cfg_len = s.len;
      @(negedge axis_clk);
      go      = 1'b0;
      cfg_len = 32'hDEAD_BEEF;
      check({s.name, ".busy_after_go"}, 64'(busy), 64'd1);
      check({s.name, ".err_cleared"}, {err, err_code, err_idx}, 64'd0);
      dones = 0;
      fired = 0;
      for (int i = 0; i < 4000 && busy; i++) begin
         @(negedge axis_clk);
         go = 1'b0;
         if (done) dones++;
         if (s.mid_go != 0 && !fired && (wr_addr_q.size() - base_w) == s.mid_go) begin
            go      = 1'b1;
            cfg_len = 32'd7;
            fired   = 1;
         end
      end
      go = 1'b0;
      check({s.name, ".busy_end"}, 64'(busy), 64'd0);
      check({s.name, ".done_pulses"}, 64'(dones), 64'(s.exp_done));
      check({s.name, ".err"}, {err, err_code, err_idx}, {s.exp_err, s.exp_code, s.exp_idx});
      check({s.name, ".n_writes"}, 64'(wr_addr_q.size() - base_w), 64'd13);
      for (int k = 0; k < 13; k++) begin
         got = (base_w + k < wr_addr_q.size()) ? {wr_addr_q[base_w+k], wr_data_q[base_w+k]} : 'x;
         check($sformatf("%s.wr%0d", s.name, k), 64'(got), 64'(exp_wr(k, s.len)));
      end
      check({s.name, ".tap_reads"}, 64'(tap_reads - base_tr), 64'd11);
      check({s.name, ".protocol"}, 64'(viol - base_v), 64'd0);
      if (s.never_done) begin
         lat = cyc - start_cyc;
         check({s.name, ".timeout_latency_ok"}, 64'(lat >= 198 && lat <= 212), 64'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      scen_t scen [7];
      int    taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
      bit    found;
      for (int k = 0; k < 16; k++) coef_tab[k] = (k < 11) ? 32'(taps[k]) : 32'd0;

      scen[0] = '{"basic",     0, 0, -1, 0, 0, 32'd600, 1'b0, 2'd0, 4'd0, 1};
      scen[1] = '{"aw_first",  1, 3, -1, 0, 0, 32'd600, 1'b0, 2'd0, 4'd0, 1};
      scen[2] = '{"w_first",   4, 1, -1, 0, 0, 32'd600, 1'b0, 2'd0, 4'd0, 1};
      scen[3] = '{"corrupt5",  0, 0,  5, 0, 0, 32'd600, 1'b1, 2'd1, 4'd5, 1};
      scen[4] = '{"mid_go",    1, 1, -1, 0, 5, 32'd600, 1'b0, 2'd0, 4'd0, 1};
      scen[5] = '{"timeout",   0, 0, -1, 1, 0, 32'd600, 1'b1, 2'd2, 4'd0, 0};
      scen[6] = '{"recover",   0, 2, -1, 0, 0, 32'd321, 1'b0, 2'd0, 4'd0, 1};

      repeat (3) @(negedge axis_clk);
      check("reset_outputs",
            {awvalid, wvalid, arvalid, rready, busy, done, err, err_code, err_idx, coef_idx,
             awaddr, araddr}, 64'd0);
      check("reset_wdata", 64'(wdata), 64'd0);
      axis_rst_n = 1'b1;
      repeat (2) @(negedge axis_clk);

      for (int i = 0; i < 7; i++) run_scenario(scen[i]);

      // Reset while the tap 3 write is on the bus
      aw_lat = 2;
      w_lat  = 2;
      corrupt_idx = -1;
      never_done  = 0;
      @(negedge axis_clk);
      go      = 1'b1;
      cfg_len = 32'd600;
      @(negedge axis_clk);
      go    = 1'b0;
      found = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge axis_clk);
         if (awvalid && awaddr == 12'h02C) begin
            found = 1;
            break;
         end
      end
      check("rst.reached_tap3", 64'(found), 64'd1);
      #2 axis_rst_n = 1'b0;
      #1 check("rst.async_clear", {awvalid, wvalid, arvalid, rready, busy, done, err}, 64'd0);
      @(negedge axis_clk);
      @(negedge axis_clk);
      axis_rst_n = 1'b1;
      run_scenario('{"after_rst", 2, 2, -1, 0, 0, 32'd600, 1'b0, 2'd0, 4'd0, 1});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
